node_mac_stream: RTL

Streaming, multi-lane fixed-point neuron that computes one dense-layer output as bias + Σ input·weight over N_IN operands. It accepts LANES operand pairs per beat on a valid/ready stream and accumulates at full precision. A single bias is added, then the result is rounded, saturated and handed downstream on a second valid/ready stream. The block is instantiated once per output node in the fully-connected stage of the CNN datapath, fed by the input/weight buffer sequencer.

---
 rtl/node_mac_pkg.sv | 52 +++++
 rtl/mac_lane_tree.sv | 33 +++
 rtl/node_mac_stream.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/node_mac_pkg.sv
// node_mac_pkg: shared types and helpers for node_mac_stream.
//   state_e    - neuron FSM states (IDLE, ACCUM, FINAL, OUT)
//   calc_acc_w - full-precision accumulator width for DW-bit operands, N_IN terms
//   calc_beats - number of input beats per neuron, ceil(N_IN/LANES)
//   saturate   - clamps a wide signed value into a DW-bit signed range and
//                reports whether clipping occurred
package node_mac_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        FINAL,
        OUT
    } state_e;

    // Working widths for saturate(): wide enough for any accumulator we build.
    localparam int SAT_W  = 128;
    localparam int SAT_VW = 64;

    typedef struct packed {
        logic [SAT_VW-1:0] val;
        logic              sat;
    } sat_res_t;

    function automatic int calc_acc_w(input int dw, input int n_in);
        return 2 * dw + $clog2(n_in) + 1;
    endfunction

    function automatic int calc_beats(input int n_in, input int lanes);
        return (n_in + lanes - 1) / lanes;
    endfunction

    function automatic sat_res_t saturate(input logic signed [SAT_W-1:0] r, input int dw);
        logic signed [SAT_W-1:0] max_v;
        logic signed [SAT_W-1:0] min_v;
        sat_res_t                res;
        max_v   = (SAT_W'(1) << (dw - 1)) - SAT_W'(1);
        min_v   = -max_v - 1;
        res.val = r[SAT_VW-1:0];
        res.sat = 1'b0;
        if (r > max_v) begin
            res.val = max_v[SAT_VW-1:0];
            res.sat = 1'b1;
        end else if (r < min_v) begin
            // Low DW bits of -2^(DW-1) are 100..0, the most negative code.
            res.val = min_v[SAT_VW-1:0];
            res.sat = 1'b1;
        end
        return res;
    endfunction

endpackage

// File: rtl/mac_lane_tree.sv
// mac_lane_tree: one beat of the neuron dot product.
//   in_data   [LANES][DW]  signed activations
//   in_weight [LANES][DW]  signed weights, lane-aligned with in_data
//   lane_vld  [LANES]      lanes with 0 contribute nothing (tail of last beat)
//   beat_sum  [ACC_W]      sign-extended sum of the lane products (Q.2FRAC)
module mac_lane_tree #(
    parameter int DW    = 16,
    parameter int LANES = 4,
    parameter int ACC_W = 41
) (
    input  logic [LANES-1:0][DW-1:0] in_data,
    input  logic [LANES-1:0][DW-1:0] in_weight,
    input  logic [LANES-1:0]         lane_vld,
    output logic [ACC_W-1:0]         beat_sum
);

    logic signed [2*DW-1:0]  prod     [LANES];
    logic signed [ACC_W-1:0] prod_ext [LANES];

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign prod[l]     = $signed(in_data[l]) * $signed(in_weight[l]);
        assign prod_ext[l] = lane_vld[l] ? {{(ACC_W-2*DW){prod[l][2*DW-1]}}, prod[l]}
                                         : '0;
    end

    always_comb begin
        beat_sum = '0;
        for (int l = 0; l < LANES; l++) begin
            beat_sum = beat_sum + prod_ext[l];
        end
    end

endmodule

// File: rtl/node_mac_stream.sv
// node_mac_stream: streaming fixed-point neuron, out = sat(round(bias + sum(x*w))).
//   clk, rst           rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready  input beat handshake (LANES operand pairs per beat)
//   in_data, in_weight [LANES][DW] signed operands, lane 0 = lowest index
//   bias               [DW] signed bias, sampled with the first beat
//   out_valid/out_ready result handshake
//   out_data           [DW] rounded, saturated result
//   out_sat            clipping occurred for this result
// Optional feature: define NODE_MAC_RELU_EN to clamp negative results to 0
// (out_sat then only reports positive clipping).
module node_mac_stream
    import node_mac_pkg::*;
#(
    parameter int DW    = 16,
    parameter int N_IN  = 200,
    parameter int LANES = 4,
    parameter int FRAC  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [LANES-1:0][DW-1:0] in_data,
    input  logic [LANES-1:0][DW-1:0] in_weight,
    input  logic [DW-1:0]            bias,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DW-1:0]            out_data,
    output logic                     out_sat
);

    localparam int BEATS = calc_beats(N_IN, LANES);
    localparam int ACC_W = calc_acc_w(DW, N_IN);
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    state_e             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [DW-1:0]      bias_q, bias_d;
    logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic               out_valid_q, out_valid_d;
    logic [DW-1:0]      out_data_q, out_data_d;
    logic               out_sat_q, out_sat_d;

    logic [LANES-1:0]   lane_vld;
    logic [ACC_W-1:0]   beat_sum;

    logic signed [SAT_W-1:0] acc_ext;
    logic signed [SAT_W-1:0] bias_ext;
    logic signed [SAT_W-1:0] t_full;
    logic signed [SAT_W-1:0] r_full;
    sat_res_t                sat_res;
    logic                    unused_sat_val;

    // Lanes past N_IN only exist on the final beat; mask them by global index.
    always_comb begin
        lane_vld = '0;
        for (int l = 0; l < LANES; l++) begin
            lane_vld[l] = ((32'(beat_cnt_q) * LANES + l) < N_IN);
        end
    end

    mac_lane_tree #(
        .DW    (DW),
        .LANES (LANES),
        .ACC_W (ACC_W)
    ) u_tree (
        .in_data   (in_data),
        .in_weight (in_weight),
        .lane_vld  (lane_vld),
        .beat_sum  (beat_sum)
    );

    // Bias aligned to Q.2FRAC, plus half an output LSB, then floor-shift:
    // rounds half-up toward +inf.
    always_comb begin
        acc_ext  = {{(SAT_W-ACC_W){acc_q[ACC_W-1]}}, acc_q};
        bias_ext = {{(SAT_W-DW){bias_q[DW-1]}}, bias_q};
        t_full   = acc_ext + (bias_ext <<< FRAC) + (SAT_W'(1) << (FRAC - 1));
        r_full   = t_full >>> FRAC;
        sat_res  = saturate(r_full, DW);
`ifdef NODE_MAC_RELU_EN
        if (r_full < 0) begin
            sat_res.val = '0;
            sat_res.sat = 1'b0;
        end
`endif
    end

    assign unused_sat_val = ^sat_res.val;

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        bias_d      = bias_q;
        beat_cnt_d  = beat_cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sat_d   = out_sat_q;
        in_ready    = 1'b0;

        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    acc_d      = beat_sum;
                    bias_d     = bias;
                    beat_cnt_d = CNT_W'(1);
                    state_d    = (BEATS == 1) ? FINAL : ACCUM;
                end
            end
            ACCUM: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    acc_d      = acc_q + beat_sum;
                    beat_cnt_d = beat_cnt_q + CNT_W'(1);
                    if (beat_cnt_q == CNT_W'(BEATS - 1)) begin
                        state_d = FINAL;
                    end
                end
            end
            FINAL: begin
                out_data_d  = sat_res.val[DW-1:0];
                out_sat_d   = sat_res.sat;
                out_valid_d = 1'b1;
                beat_cnt_d  = '0;
                state_d     = OUT;
            end
            OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    acc_d       = '0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            bias_q      <= '0;
            beat_cnt_q  <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            bias_q      <= bias_d;
            beat_cnt_q  <= beat_cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sat_q   <= out_sat_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;

endmodule
